seq_add_sub: RTL and testbench
==============================

Name: seq_add_sub

Overview:
- Parametrised, multi-cycle successor to the single-bit adder cells.
- Adds or subtracts two DATA_WIDTH-bit operands SLICE_WIDTH bits per clock. The carry is held in a register between slices.
- Intended as the area-lean add/sub engine beside the ALU.
- Uses a START/DONE handshake and produces carry-out and signed-overflow flags.

Parameters:
- DATA_WIDTH, 32: operand and result width.
- SLICE_WIDTH, 8: bits processed per cycle. Must divide DATA_WIDTH; NSLICE = DATA_WIDTH/SLICE_WIDTH must be >= 2.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  request; sampled only when the block is ready (IDLE or DONE state).
- SnA  in  1  operation select: 0 = add, 1 = subtract (A - B).
- A  in  DATA_WIDTH  operand A; sampled with START.
- B  in  DATA_WIDTH  operand B; sampled with START.
- BUSY  out  1  high while in RUN.
- DONE  out  1  one-cycle pulse; result is valid.
- Y  out  DATA_WIDTH  result; registered and held until the next completion.
- CO  out  1  final carry-out. For subtract, 1 = no borrow.
- OVF  out  1  two's-complement overflow.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; BUSY = 0, DONE = 0, Y = 0, CO = 0, OVF = 0.
  - Slice counter, carry register and operand registers cleared.
  - Reset mid-RUN aborts the operation: no DONE and no partial result on Y.
- States: IDLE, RUN, DONE. Encodings are 2-bit constants.
- IDLE:
  - START = 1 at an edge latches A into opA, (B XOR {DATA_WIDTH{SnA}}) into opB, and SnA into the carry register as carry-in.
  - Slice index set to 0; next state RUN. Otherwise stay in IDLE.
- RUN, each cycle:
  - sum = opA[idx slice] + opB[idx slice] + carry.
  - Low SLICE_WIDTH bits written into the internal accumulator slice idx; the slice carry-out goes to the carry register; idx increments.
  - On idx == NSLICE-1:
    - Y <= complete accumulator; CO <= final carry.
    - OVF <= (opA[MSB] == opB[MSB]) && (result[MSB] != opA[MSB]).
    - Next state DONE.
- DONE:
  - DONE = 1 for exactly this cycle.
  - START = 1 here is accepted like in IDLE (back-to-back issue) and goes to RUN; otherwise go to IDLE.
- START while BUSY is ignored; the latched operands are not disturbed.
- Latency: START sampled at edge t → DONE high during the cycle after edge t+NSLICE. Throughput is one op per NSLICE+1 cycles.
- Y, CO and OVF change only at the completing edge; they are stable while BUSY and stable after DONE.
- Arithmetic is modulo 2^DATA_WIDTH. No sign extension; operands are treated as raw bit vectors for Y and CO.

Decomposition:
- prj_definition.v holds:
  - the default DATA_WIDTH (via the existing data-width define);
  - SLICE_WIDTH default;
  - the state encodings SAS_IDLE / SAS_RUN / SAS_DONE.
- One sub-module: slice_adder (SLICE_WIDTH-bit ripple adder with CI/CO, built from the existing full-adder cells). It is instantiated once and muxed over slices by idx.
- FSM, counter, operand and result registers live in seq_add_sub.

Test Plan (DATA_WIDTH=32, SLICE_WIDTH=8, NSLICE=4):
1. Add: A=0x000000FF, B=0x00000001, SnA=0, START for 1 cycle
   → BUSY high 4 cycles; DONE pulses 5 cycles after START; Y=0x00000100, CO=0, OVF=0.
2. Add: A=0x7FFFFFFF, B=0x00000001 → Y=0x80000000, CO=0, OVF=1.
   Add: A=0xFFFFFFFF, B=0x00000001 → Y=0x00000000, CO=1, OVF=0.
3. Subtract: A=5, B=7, SnA=1 → Y=0xFFFFFFFE, CO=0, OVF=0.
   Then A=7, B=5 → Y=0x00000002, CO=1.
   Then A=0x80000000, B=1 → Y=0x7FFFFFFF, OVF=1.
4. Issue 0x10+0x20.
   - Pulse START with A=0xAAAAAAAA during RUN → ignored; Y=0x30.
   - Assert START in the DONE cycle with 3+4 → accepted; next DONE 5 cycles later with Y=0x7.
5. Start 0x12345678+0x11111111. Assert RST asynchronously mid-cycle at RUN idx=2
   → all outputs 0 immediately; no DONE.
   Release RST and start 1+1 → Y=2 after normal latency.

Source files
------------

// File: rtl/seq_add_sub_pkg.sv
// Shared definitions for the sequential add/sub engine: default widths,
// FSM state encodings and the bit-level full-adder cell.
package seq_add_sub_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH  = 32;
  localparam int unsigned DEFAULT_SLICE_WIDTH = 8;

  typedef enum logic [1:0] {
    SAS_IDLE = 2'b00,
    SAS_RUN  = 2'b01,
    SAS_DONE = 2'b10
  } sas_state_t;

  // Returns {carry_out, sum} of a single-bit full adder.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    full_add = {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/seq_add_sub_slice_adder.sv
// SLICE_WIDTH-bit ripple-carry adder chained from full-adder cells.
module slice_adder
  import seq_add_sub_pkg::*;
#(
  parameter int unsigned SLICE_WIDTH = DEFAULT_SLICE_WIDTH
) (
  input  logic [SLICE_WIDTH-1:0] A,
  input  logic [SLICE_WIDTH-1:0] B,
  input  logic                   CI,
  output logic [SLICE_WIDTH-1:0] S,
  output logic                   CO
);

  logic [SLICE_WIDTH:0] carry;

  assign carry[0] = CI;

  for (genvar i = 0; i < SLICE_WIDTH; i++) begin : g_fa
    assign {carry[i+1], S[i]} = full_add(A[i], B[i], carry[i]);
  end

  assign CO = carry[SLICE_WIDTH];

endmodule

// File: rtl/seq_add_sub.sv
// Multi-cycle adder/subtractor: processes SLICE_WIDTH bits per clock through a
// single shared slice adder, with a START/DONE handshake and carry/overflow flags.
module seq_add_sub
  import seq_add_sub_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned SLICE_WIDTH = DEFAULT_SLICE_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  SnA,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DATA_WIDTH-1:0] Y,
  output logic                  CO,
  output logic                  OVF
);

  localparam int unsigned NSLICE = DATA_WIDTH / SLICE_WIDTH;
  localparam int unsigned IDX_W  = $clog2(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
  localparam int unsigned MSB = DATA_WIDTH - 1;

  sas_state_t state, state_next;

  logic [IDX_W-1:0]       idx;
  logic [DATA_WIDTH-1:0]  op_a;
  logic [DATA_WIDTH-1:0]  op_b;
  logic [DATA_WIDTH-1:0]  acc;
  logic [DATA_WIDTH-1:0]  result;
  logic                   carry;
  logic [SLICE_WIDTH-1:0] sl_a;
  logic [SLICE_WIDTH-1:0] sl_b;
  logic [SLICE_WIDTH-1:0] sl_s;
  logic                   sl_co;
  logic                   accept;
  logic                   last;

  // START is only honoured when ready; requests during RUN are dropped.
  assign accept = START && ((state == SAS_IDLE) || (state == SAS_DONE));
  assign last   = (state == SAS_RUN) && (idx == LAST_IDX);

  always_comb begin
    sl_a = op_a[idx*SLICE_WIDTH +: SLICE_WIDTH];
    sl_b = op_b[idx*SLICE_WIDTH +: SLICE_WIDTH];
  end

  slice_adder #(
    .SLICE_WIDTH(SLICE_WIDTH)
  ) u_slice_adder (
    .A (sl_a),
    .B (sl_b),
    .CI(carry),
    .S (sl_s),
    .CO(sl_co)
  );

  // Full result as it will stand once the current slice is written back.
  always_comb begin
    result = acc;
    result[idx*SLICE_WIDTH +: SLICE_WIDTH] = sl_s;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= SAS_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SAS_IDLE: if (START) state_next = SAS_RUN;
      SAS_RUN:  if (idx == LAST_IDX) state_next = SAS_DONE;
      SAS_DONE: state_next = START ? SAS_RUN : SAS_IDLE;
      default:  state_next = SAS_IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state == SAS_RUN);
    DONE = (state == SAS_DONE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      Y     <= '0;
      CO    <= 1'b0;
      OVF   <= 1'b0;
    end else if (accept) begin
      // Subtract as A + ~B + 1: invert B here, inject the +1 as carry-in.
      op_a  <= A;
      op_b  <= B ^ {DATA_WIDTH{SnA}};
      carry <= SnA;
      idx   <= '0;
    end else if (state == SAS_RUN) begin
      acc[idx*SLICE_WIDTH +: SLICE_WIDTH] <= sl_s;
      carry <= sl_co;
      idx   <= idx + 1'b1;
      if (last) begin
        Y   <= result;
        CO  <= sl_co;
        OVF <= (op_a[MSB] == op_b[MSB]) && (result[MSB] != op_a[MSB]);
      end
    end
  end

endmodule

// File: tb/tb_seq_add_sub.sv
// Self-checking bench for seq_add_sub (32-bit, 8-bit slices) against a
// plain-arithmetic reference model.
module tb_seq_add_sub;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sna;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] y;
  logic        co;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  seq_add_sub #(
    .DATA_WIDTH (32),
    .SLICE_WIDTH(8)
  ) dut (
    .CLK  (clk),
    .RST  (rst),
    .START(start),
    .SnA  (sna),
    .A    (a),
    .B    (b),
    .BUSY (busy),
    .DONE (done),
    .Y    (y),
    .CO   (co),
    .OVF  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: unsigned arithmetic for Y/CO, signed 64-bit range check for OVF.
  function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic msub,
                                output logic [31:0] ey, output logic eco, output logic eovf);
    longint sa, sb, r;
    logic [32:0] s;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (!msub) begin
      s   = {1'b0, ma} + {1'b0, mb};
      ey  = s[31:0];
      eco = s[32];
      r   = sa + sb;
    end else begin
      ey  = ma - mb;
      eco = (ma >= mb);
      r   = sa - sb;
    end
    eovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  // Issues one operation and waits for DONE; reports latency in negedges after the
  // accepting edge, BUSY count and whether Y held steady while running.
  task automatic do_op(input logic [31:0] oa, input logic [31:0] ob, input logic osub,
                       output int lat, output int nbusy, output logic ystable);
    logic [31:0] y0;
    @(negedge clk);
    a = oa; b = ob; sna = osub; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1; nbusy = 0; ystable = 1'b1; y0 = y;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      if (y !== y0) ystable = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; sna = 1'b0; a = '0; b = '0;
    #3;
    n_checks++;
    if ({busy, done, y, co, ovf} !== 35'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b y=%h co=%b ovf=%b, required all 0",
               busy, done, y, co, ovf);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add;
    int lat, nbusy; logic ys;
    do_op(32'h000000FF, 32'h00000001, 1'b0, lat, nbusy, ys);
    n_checks++;
    if (lat !== 5) begin n_fail++; $display("FAIL add_latency: got %0d required 5", lat); end
    n_checks++;
    if (nbusy !== 4) begin n_fail++; $display("FAIL add_busy_cycles: got %0d required 4", nbusy); end
    n_checks++;
    if (ys !== 1'b1) begin n_fail++; $display("FAIL add_y_stable_while_busy: got %b required 1", ys); end
    n_checks++;
    if ({y, co, ovf} !== {32'h00000100, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL add_result: got y=%h co=%b ovf=%b required y=00000100 co=0 ovf=0", y, co, ovf);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_single_pulse: got %b required 0", done); end
    n_checks++;
    if (y !== 32'h00000100) begin n_fail++; $display("FAIL y_held_after_done: got %h required 00000100", y); end
  endtask

  task automatic test_boundaries;
    logic [31:0] ta [5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd7, 32'h80000000};
    logic [31:0] tb [5] = '{32'h00000001, 32'h00000001, 32'd7, 32'd5, 32'h00000001};
    logic        ts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] ey; logic eco, eovf;
    int lat, nbusy; logic ys;
    for (int i = 0; i < 5; i++) begin
      model(ta[i], tb[i], ts[i], ey, eco, eovf);
      do_op(ta[i], tb[i], ts[i], lat, nbusy, ys);
      n_checks++;
      if ({y, co, ovf, lat} !== {ey, eco, eovf, 5}) begin
        n_fail++;
        $display("FAIL boundary_%0d: got y=%h co=%b ovf=%b lat=%0d required y=%h co=%b ovf=%b lat=5",
                 i, y, co, ovf, lat, ey, eco, eovf);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    a = 32'h10; b = 32'h20; sna = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 32'hAAAAAAAA; b = 32'h55555555; sna = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    n_checks++;
    if ({done, y, co, ovf} !== {1'b1, 32'h30, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL start_ignored_while_busy: got done=%b y=%h co=%b ovf=%b required done=1 y=00000030 co=0 ovf=0",
                         done, y, co, ovf);
    end
    a = 32'd3; b = 32'd4; sna = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accepted: busy got %b required 1", busy); end
    lat = 1;
    while (!done && lat < 20) begin
      if (y !== 32'h30) begin n_fail++; n_checks++; $display("FAIL b2b_y_held: got %h required 00000030", y); end
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if ({lat, y} !== {32'd5, 32'h7}) begin
      n_fail++; $display("FAIL b2b_result: got lat=%0d y=%h required lat=5 y=00000007", lat, y);
    end
  endtask

  task automatic test_async_reset;
    int lat, nbusy, seen; logic ys;
    @(negedge clk);
    a = 32'h12345678; b = 32'h11111111; sna = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, y, co, ovf} !== 35'b0) begin
      n_fail++; $display("FAIL async_reset_outputs: got busy=%b done=%b y=%h co=%b ovf=%b required all 0",
                         busy, done, y, co, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin @(negedge clk); if (done || y !== 32'h0) seen++; end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL reset_aborts_op: got %0d cycles with done/partial y, required 0", seen); end
    do_op(32'd1, 32'd1, 1'b0, lat, nbusy, ys);
    n_checks++;
    if ({lat, y} !== {32'd5, 32'd2}) begin
      n_fail++; $display("FAIL after_reset_op: got lat=%0d y=%h required lat=5 y=00000002", lat, y);
    end
  endtask

  task automatic test_random;
    logic [31:0] ra, rb, ey; logic rs, eco, eovf;
    int lat, nbusy; logic ys;
    for (int i = 0; i < 60; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      if (i % 4 == 1) rb = ~ra;
      if (i % 4 == 2) ra = {1'b0, ra[30:0]} | 32'h7FFF0000;
      model(ra, rb, rs, ey, eco, eovf);
      do_op(ra, rb, rs, lat, nbusy, ys);
      n_checks++;
      if ({y, co, ovf, lat, nbusy} !== {ey, eco, eovf, 32'd5, 32'd4}) begin
        n_fail++;
        $display("FAIL random_%0d: a=%h b=%h sub=%b got y=%h co=%b ovf=%b lat=%0d busy=%0d required y=%h co=%b ovf=%b lat=5 busy=4",
                 i, ra, rb, rs, y, co, ovf, lat, nbusy, ey, eco, eovf);
      end
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_boundaries;
    test_back_to_back;
    test_async_reset;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
